// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage core: load-use stalls, taken-branch
// flushes and multi-cycle mult/div occupancy of EX, plus a saturating stall counter.
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [5:0]  id_opcode,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_mdu,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        busy_state,
  output logic [15:0] stall_count
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STAT_W = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic {RUN, MDU_BUSY} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    mdu_cnt_q, mdu_cnt_d;
  logic [STAT_W-1:0]   stall_q;
  logic                rs_used, rt_used, load_use;

  // Source-register usage decode and load-use detection
  always_comb begin
    rs_used  = !(id_opcode == OP_J || id_opcode == OP_JAL || id_opcode == OP_LUI);
    rt_used  = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
               (id_opcode == OP_BEQ)   || (id_opcode == OP_BNE);
    load_use = id_valid && ex_mem_read && (ex_rt != 5'd0) &&
               ((rs_used && (ex_rt == id_rs)) || (rt_used && (ex_rt == id_rt)));
  end

  // Next-state and pipeline control; flush has priority over all stalls
  always_comb begin
    state_d      = state_q;
    mdu_cnt_d    = mdu_cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_branch_taken) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end else if (id_valid && id_mdu) begin
            mdu_cnt_d = CNT_W'(MDU_LAT - 1);
            state_d   = MDU_BUSY;
          end
        end
        MDU_BUSY: begin
          if (ex_branch_taken) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            mdu_cnt_d    = '0;
            state_d      = RUN;
          end else begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            mdu_cnt_d    = mdu_cnt_q - CNT_W'(1);
            // A zero count here can only be stale; never stay busy on it
            if (mdu_cnt_q <= CNT_W'(1)) state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, MDU counter and saturating stall statistic
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      mdu_cnt_q <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      mdu_cnt_q <= mdu_cnt_d;
      if (!pc_write && (stall_q != {STAT_W{1'b1}}))
        stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign busy_state  = (state_q == MDU_BUSY);
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected control
// outputs; a negedge monitor pops and compares every presented cycle.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_mdu = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        ex_branch_taken = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, busy_state;
  logic [15:0] stall_count;

  hazard_ctrl #(.MDU_LAT(4)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_mdu(id_mdu), .ex_mem_read(ex_mem_read),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .busy_state(busy_state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble}
  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1011;
  localparam logic [3:0] RSTO  = 4'b0011;

  typedef struct {
    string       tag;
    logic [3:0]  ctl;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: outputs are combinational, so every cycle presents a response
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [3:0] act;
      e   = exp_q.pop_front();
      act = {pc_write, if_id_write, if_id_flush, id_ex_bubble};
      checks++;
      if (act !== e.ctl || busy_state !== e.busy || stall_count !== e.cnt) begin
        failures++;
        $display("FAIL %s: got ctl=%b busy=%b cnt=%h, want ctl=%b busy=%b cnt=%h",
                 e.tag, act, busy_state, stall_count, e.ctl, e.busy, e.cnt);
      end
    end
  end

  task automatic cyc(input string tag, input logic r, input logic v,
                     input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                     input logic mdu, input logic mr, input logic [4:0] ert,
                     input logic br, input logic [3:0] ctl, input logic busy,
                     input logic [15:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt;
    id_mdu = mdu; ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br;
    e.tag = tag; e.ctl = ctl; e.busy = busy; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    cyc("reset",        1, 0, 6'o00, 0, 0, 0, 0, 0, 0, RSTO,  0, 16'd0);
    cyc("idle",         0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'd0);
    cyc("load_use_rs",  0, 1, 6'b000000, 8, 3, 0, 1, 8, 0, STALL, 0, 16'd0);
    cyc("after_bubble", 0, 1, 6'b000000, 8, 3, 0, 0, 0, 0, NORM,  0, 16'd1);
    cyc("ex_rt_zero",   0, 1, 6'b000000, 0, 0, 0, 1, 0, 0, NORM,  0, 16'd1);
    cyc("lui_rt",       0, 1, 6'b001111, 3, 9, 0, 1, 9, 0, NORM,  0, 16'd1);
    cyc("sw_rt_hazard", 0, 1, 6'b101011, 1, 9, 0, 1, 9, 0, STALL, 0, 16'd1);
    cyc("lw_rt_unused", 0, 1, 6'b100011, 2, 9, 0, 1, 9, 0, NORM,  0, 16'd2);
    cyc("j_rs_unused",  0, 1, 6'b000010, 9, 0, 0, 1, 9, 0, NORM,  0, 16'd2);
    cyc("invalid_id",   0, 0, 6'b000000, 9, 9, 1, 1, 9, 0, NORM,  0, 16'd2);
    cyc("mdu_issue",    0, 1, 6'b000000, 1, 2, 1, 0, 0, 0, NORM,  0, 16'd2);
    cyc("mdu_busy1",    0, 0, 6'o00, 0, 0, 0, 0, 0, 0, STALL, 1, 16'd2);
    cyc("mdu_busy2",    0, 0, 6'o00, 0, 0, 0, 0, 0, 0, STALL, 1, 16'd3);
    cyc("mdu_busy3",    0, 0, 6'o00, 0, 0, 0, 0, 0, 0, STALL, 1, 16'd4);
    cyc("mdu_done",     0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'd5);
    cyc("branch_prio",  0, 1, 6'b000000, 8, 0, 1, 1, 8, 1, FLUSH, 0, 16'd5);
    cyc("post_branch",  0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'd5);
    cyc("mdu_issue2",   0, 1, 6'b000000, 1, 2, 1, 0, 0, 0, NORM,  0, 16'd5);
    cyc("busy_then_br", 0, 0, 6'o00, 0, 0, 0, 0, 0, 0, STALL, 1, 16'd5);
    cyc("branch_busy",  0, 0, 6'o00, 0, 0, 0, 0, 0, 1, FLUSH, 1, 16'd6);
    cyc("busy_aborted", 0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'd6);
    cyc("mdu_issue3",   0, 1, 6'b000000, 1, 2, 1, 0, 0, 0, NORM,  0, 16'd6);
    cyc("busy_pre_rst", 0, 0, 6'o00, 0, 0, 0, 0, 0, 0, STALL, 1, 16'd6);
    cyc("rst_in_busy",  1, 0, 6'o00, 0, 0, 0, 0, 0, 0, RSTO,  1, 16'd7);
    cyc("after_rst",    0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'd0);
    cyc("after_rst2",   0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'd0);
    for (int i = 0; i < 65540; i++)
      cyc("saturate", 0, 1, 6'b000000, 8, 0, 0, 1, 8, 0, STALL, 0,
          (i > 65535) ? 16'hFFFF : 16'(i));
    cyc("sat_hold",     0, 0, 6'o00, 0, 0, 0, 0, 0, 0, NORM,  0, 16'hFFFF);
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
